seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider for the 4-bit CPU datapath; the inverse of the

---
 rtl/cpu_pkg.sv | 9 +
 rtl/ripple_subtractor.sv | 20 ++
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider state encoding and default datapath width
package cpu_pkg;
   localparam int DIV_WIDTH = 4;
   typedef enum logic [1:0] {
      DIV_STATE_IDLE = 2'd0,
      DIV_STATE_CALC = 2'd1,
      DIV_STATE_DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/ripple_subtractor.sv
// ripple_subtractor: a_i - b_i as a chain of full-subtractor cells (a + ~b + 1)
//   a_i, b_i : N-bit operands
//   diff_o   : N-bit difference
//   borrow_o : 1 when b_i > a_i
module ripple_subtractor #(
   parameter int N = 5
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] diff_o,
   output logic         borrow_o
);
   logic [N:0] w_c;
   assign w_c[0] = 1'b1;
   for (genvar i = 0; i < N; i++) begin : g_cell
      assign diff_o[i]  = a_i[i] ^ ~b_i[i] ^ w_c[i];
      assign w_c[i+1]   = (a_i[i] & ~b_i[i]) | (w_c[i] & (a_i[i] ^ ~b_i[i]));
   end
   assign borrow_o = ~w_c[N];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one subtract stage per clock
//   clk_i, rst_i (async, active-high)
//   start_i, dividend_i, divisor_i : request and operands, accepted while ready_o=1
//   ready_o, busy_o, done_o        : handshake (done_o is a 1-cycle pulse)
//   quotient_o, remainder_o, div_by_zero_o : results, held until next accepted start
module seq_divider
   import cpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);
   localparam int CW = $clog2(WIDTH + 1);
   div_state_e       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_r;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH:0]   w_s;
   logic [WIDTH:0]   w_t;
   logic             w_borrow;
   logic [WIDTH:0]   w_r_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_unused_msb;
   // partial remainder stays below the divisor, so its top bit never feeds the next shift
   assign w_unused_msb = r_r[WIDTH];
   assign w_s      = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_r_next = w_borrow ? w_s : w_t;
   assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
   ripple_subtractor #(.N(WIDTH + 1)) u_sub (
      .a_i      (w_s),
      .b_i      ({1'b0, r_d}),
      .diff_o   (w_t),
      .borrow_o (w_borrow)
   );
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= DIV_STATE_IDLE;
         r_cnt         <= '0;
         r_r           <= '0;
         r_q           <= '0;
         r_d           <= '0;
         ready_o       <= 1'b1;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            DIV_STATE_CALC: begin
               r_r   <= w_r_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state     <= DIV_STATE_DONE;
                  ready_o     <= 1'b1;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  quotient_o  <= w_q_next;
                  remainder_o <= w_r_next[WIDTH-1:0];
               end
            end
            DIV_STATE_IDLE, DIV_STATE_DONE: begin
               if (start_i && divisor_i == '0) begin
                  // divide by zero skips iteration and reports immediately
                  r_state       <= DIV_STATE_DONE;
                  done_o        <= 1'b1;
                  quotient_o    <= '1;
                  remainder_o   <= dividend_i;
                  div_by_zero_o <= 1'b1;
               end else if (start_i) begin
                  r_state       <= DIV_STATE_CALC;
                  r_q           <= dividend_i;
                  r_d           <= divisor_i;
                  r_r           <= '0;
                  r_cnt         <= CW'(WIDTH);
                  ready_o       <= 1'b0;
                  busy_o        <= 1'b1;
                  quotient_o    <= '0;
                  remainder_o   <= '0;
                  div_by_zero_o <= 1'b0;
               end else begin
                  r_state <= DIV_STATE_IDLE;
               end
            end
            default: begin
               r_state <= DIV_STATE_IDLE;
               ready_o <= 1'b1;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and exhaustive self-checking bench for seq_divider
module tb_seq_divider;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic [3:0] dividend_i = '0;
   logic [3:0] divisor_i = '0;
   logic       ready_o, busy_o, done_o, div_by_zero_o;
   logic [3:0] quotient_o, remainder_o;
   int         tests = 0;
   int         fails = 0;
   logic       mon_en = 1'b0;
   seq_divider #(.WIDTH(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .ready_o       (ready_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .div_by_zero_o (div_by_zero_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!done_o && n < 20) begin
         tick();
         n++;
      end
      if (!done_o) check("done_timeout", 32'(done_o), 1);
   endtask
   always @(negedge clk_i) if (mon_en) check("rdy_busy_excl", 32'(ready_o ^ busy_o), 1);
   task automatic run(input logic [3:0] a, input logic [3:0] b);
      int n;
      logic [3:0] eq, er;
      logic ez;
      ez = (b == 4'd0);
      eq = ez ? 4'hF : a / b;
      er = ez ? a : a % b;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      tick();
      start_i = 1'b0;
      if (!ez) begin
         check("busy_after_start", 32'(busy_o), 1);
         check("q_cleared", 32'(quotient_o), 0);
      end
      wait_done(n);
      check("latency", n, ez ? 0 : 4);
      check("quotient", 32'(quotient_o), 32'(eq));
      check("remainder", 32'(remainder_o), 32'(er));
      check("dbz", 32'(div_by_zero_o), 32'(ez));
      tick();
      check("done_pulse_end", 32'(done_o), 0);
      check("q_held", 32'(quotient_o), 32'(eq));
      check("ready_idle", 32'(ready_o), 1);
   endtask
   initial begin
      int n;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", 32'(ready_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_q", 32'(quotient_o), 0);
      check("rst_r", 32'(remainder_o), 0);
      check("rst_dbz", 32'(div_by_zero_o), 0);
      rst_i  = 1'b0;
      mon_en = 1'b1;
      tick();
      run(4'd13, 4'd3);
      run(4'd7, 4'd0);
      // back-to-back: new start in the DONE cycle
      dividend_i = 4'd15; divisor_i = 4'd1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(n);
      check("b2b_q1", 32'(quotient_o), 15);
      check("b2b_r1", 32'(remainder_o), 0);
      dividend_i = 4'd3; divisor_i = 4'd5; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("b2b_done_low", 32'(done_o), 0);
      check("b2b_busy", 32'(busy_o), 1);
      wait_done(n);
      check("b2b_lat", n, 4);
      check("b2b_q2", 32'(quotient_o), 0);
      check("b2b_r2", 32'(remainder_o), 3);
      tick();
      // start held with changing operands during CALC is ignored
      dividend_i = 4'd13; divisor_i = 4'd3; start_i = 1'b1;
      tick();
      dividend_i = 4'd2; divisor_i = 4'd1;
      tick();
      tick();
      start_i = 1'b0;
      wait_done(n);
      check("hold_lat", n, 2);
      check("hold_q", 32'(quotient_o), 4);
      check("hold_r", 32'(remainder_o), 1);
      tick();
      // async reset in the middle of CALC
      dividend_i = 4'd9; divisor_i = 4'd2; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      check("pre_rst_busy", 32'(busy_o), 1);
      #2 rst_i = 1'b1;
      #1;
      check("arst_ready", 32'(ready_o), 1);
      check("arst_busy", 32'(busy_o), 0);
      check("arst_done", 32'(done_o), 0);
      check("arst_q", 32'(quotient_o), 0);
      check("arst_r", 32'(remainder_o), 0);
      rst_i = 1'b0;
      tick();
      run(4'd9, 4'd2);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run(4'(a), 4'(b));
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
